// File: rtl/doodle_pkg.sv
// doodle_pkg
// Shared constants and types for the platform scroller: slot count, screen
// height, respawn X offset, platform width, LFSR seed, sweep FSM state type
// and the power-on slot layout.
package doodle_pkg;

    localparam int          NUM_PLAT  = 15;
    localparam int          SCREEN_H  = 480;
    localparam int          X_OFS     = 32;
    localparam int          PLAT_W    = 64;
    localparam int          IDX_W     = 4;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    // Reset layout: slots evenly staggered across and down the screen.
    function automatic logic [9:0] reset_x(input int unsigned i);
        return 10'(20 + 40 * i);
    endfunction

    function automatic logic [9:0] reset_y(input int unsigned i);
        return 10'(32 * i);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11 (maximal length).
// Advances every clock; seeded with a non-zero value so it never locks up.
// Ports:
//   Clk    - system clock
//   Reset  - asynchronous active-high reset, reloads the seed
//   value  - current LFSR state
module lfsr16 (
    input  logic        Clk,
    input  logic        Reset,
    output logic [15:0] value
);
    import doodle_pkg::*;

    logic feedback;

    assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            value <= LFSR_SEED;
        end else begin
            value <= {value[14:0], feedback};
        end
    end

endmodule

// File: rtl/platform_scroll_ctrl.sv
// platform_scroll_ctrl
// Holds the X/Y position of every platform slot. On each rising edge of the
// (asynchronous) vertical sync, if a non-zero displacement is requested, the
// slots are swept one per clock and moved down by that many lines. A slot that
// falls off the bottom wraps to the top with a new random X and bumps score.
// Ports:
//   Clk          - 50 MHz system clock
//   Reset        - asynchronous active-high reset
//   frame_clk    - VGA vertical sync, asynchronous to Clk
//   displacement - lines to scroll this frame
//   rd_idx       - slot read address
//   rd_x, rd_y   - combinational read of slot rd_idx (0 when out of range)
//   busy         - sweep in progress
//   sweep_done   - one-cycle pulse after the last slot is processed
//   overrun      - sticky: a frame edge arrived while a sweep was active
//   score        - platforms recycled since reset (wraps)
module platform_scroll_ctrl #(
    parameter int NUM_PLAT = doodle_pkg::NUM_PLAT,
    parameter int SCREEN_H = doodle_pkg::SCREEN_H,
    parameter int X_OFS    = doodle_pkg::X_OFS
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [7:0]  displacement,
    input  logic [3:0]  rd_idx,
    output logic [9:0]  rd_x,
    output logic [9:0]  rd_y,
    output logic        busy,
    output logic        sweep_done,
    output logic        overrun,
    output logic [15:0] score
);
    import doodle_pkg::*;

    logic       sync1, sync2, frame_prev, frame_tick;
    state_t     state, next_state;
    logic       start;
    logic [3:0] idx;
    logic       last_slot;
    logic [7:0] disp_lat;
    logic [15:0] lfsr_val;
    logic       unused_lfsr;

    logic [9:0] x_mem [NUM_PLAT];
    logic [9:0] y_mem [NUM_PLAT];
    logic [9:0] ny;
    logic       wrap;

    lfsr16 u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .value (lfsr_val)
    );

    assign unused_lfsr = ^lfsr_val[15:9];

    // Two-flop synchronizer plus edge flop; all clear on reset so a frame_clk
    // already high at release needs two clocks to propagate before a tick.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            frame_prev <= 1'b0;
        end else begin
            sync1      <= frame_clk;
            sync2      <= sync1;
            frame_prev <= sync2;
        end
    end

    assign frame_tick = sync2 & ~frame_prev;
    assign last_slot  = (idx == 4'(NUM_PLAT - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        busy       = 1'b0;
        sweep_done = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick && (displacement != '0)) begin
                    next_state = SWEEP;
                    start      = 1'b1;
                end
            end
            SWEEP: begin
                busy = 1'b1;
                if (last_slot) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                sweep_done = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // idx holds at the last slot rather than stepping past the array.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            idx      <= '0;
            disp_lat <= '0;
            overrun  <= 1'b0;
        end else begin
            if (start) begin
                idx      <= '0;
                disp_lat <= displacement;
            end else if (busy && !last_slot) begin
                idx <= idx + 4'd1;
            end
            if (frame_tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    // y < SCREEN_H and disp_lat <= 255, so the sum always fits in 10 bits.
    assign ny   = y_mem[idx] + {2'b00, disp_lat};
    assign wrap = (ny >= 10'(SCREEN_H));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NUM_PLAT; i++) begin
                x_mem[i] <= reset_x(i);
                y_mem[i] <= reset_y(i);
            end
            score <= '0;
        end else if (busy) begin
            if (wrap) begin
                y_mem[idx] <= ny - 10'(SCREEN_H);
                x_mem[idx] <= {1'b0, lfsr_val[8:0]} + 10'(X_OFS);
                score      <= score + 16'd1;
            end else begin
                y_mem[idx] <= ny;
            end
        end
    end

    always_comb begin
        rd_x = '0;
        rd_y = '0;
        if (int'(rd_idx) < NUM_PLAT) begin
            rd_x = x_mem[rd_idx];
            rd_y = y_mem[rd_idx];
        end
    end

endmodule
